rram_adc_readout_packer: RTL and testbench
==========================================

Name: rram_adc_readout_packer

Overview:
- Parametrised ADC readout stage between the crossbar's shared-ADC array and the output data FIFO.
- Converts NUM_ADC thermometer codes to binary.
- Two modes:
  - Raw: one sample per channel.
  - Accumulate: sums N samples per channel, for multi-cycle/partial-sum reads.
- Packs the results into DATAOUT_WIDTH words and pushes them to the output FIFO under full backpressure.
- Generalises the controller's single-shot ADC capture to configurable channel count, accumulation depth and output width.

Parameters:
- NUM_ADC, 32, number of ADC channels.
- ADC_WIDTH_THERM, 15, thermometer bits per ADC.
- ADC_WIDTH, 4, binary code width; must be >= $clog2(ADC_WIDTH_THERM+1).
- ACC_WIDTH, 16, accumulator field width; must be >= ADC_WIDTH+$clog2(MAX_ACC_CYCLES).
- MAX_ACC_CYCLES, 16, maximum samples per accumulation.
- DATAOUT_WIDTH, 64, output FIFO word width; must be a multiple of ADC_WIDTH and ACC_WIDTH.

Ports:
- CLK, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, pulse; begins a frame when idle.
- acc_mode, in, 1, 0 = raw, 1 = accumulate; sampled at start.
- acc_cycles_m1, in, $clog2(MAX_ACC_CYCLES), number of samples minus 1; sampled at start; ignored in raw mode.
- adc_valid, in, 1, one-cycle strobe: ADCOUT_THERM is valid this cycle.
- ADCOUT_THERM, in, [ADC_WIDTH_THERM-1:0] x NUM_ADC, unpacked array of thermometer codes.
- push_n_oFIFO, out, 1, active-low push.
- full_oFIFO, in, 1, output FIFO full.
- din_oFIFO, out, DATAOUT_WIDTH, output word.
- busy, out, 1, high outside IDLE.
- done, out, 1, one-cycle pulse after the final push.
- therm_err, out, 1, one-cycle pulse: a bubble was seen in an accepted sample.
- sample_drop, out, 1, one-cycle pulse: adc_valid arrived outside CAPTURE.

Behaviour:
- Reset: state IDLE; accumulators, sample counter and word index cleared; push_n_oFIFO=1; din_oFIFO=0; busy, done, therm_err and sample_drop all 0.
- Conversion: code = popcount(therm), so it is bubble-tolerant.
- therm_err: asserted when any channel has bit i=1 while bit i-1=0, for i>=1.
- Field width FW: ADC_WIDTH in raw mode, ACC_WIDTH in accumulate mode.
- Words per frame: WPF = ceil(NUM_ADC*FW/DATAOUT_WIDTH). Defaults give raw WPF=2, accumulate WPF=8.
- Packing: channel 0 occupies the LSBs of word 0, channels ascending. Unused upper bits of the last word are 0.
- FSM:
  - IDLE: start=1 latches acc_mode and acc_cycles_m1, clears accumulators and counter, moves to CAPTURE next cycle. busy rises in the same edge.
  - CAPTURE: each adc_valid adds code to each channel's accumulator (raw mode: loads it). The counter increments. On the sample where counter==acc_cycles_m1 (raw mode: first sample), move to DRAIN next cycle.
  - DRAIN: push_n_oFIFO = full_oFIFO (combinational from registered state and full). din_oFIFO = word[idx] (combinational mux of registered accumulators). Each edge with a push increments idx. The push of word WPF-1 moves to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Accumulation saturates at all-ones (cannot occur under the parameter constraints; saturation is still required).
- start while busy: ignored.
- adc_valid in IDLE/DRAIN/DONE: sample discarded, sample_drop pulses.
- full_oFIFO held high: the DRAIN state is held with idx and data unchanged. No word is skipped or duplicated.
- start and the final adc_valid in the same cycle in CAPTURE: start is ignored.
- reset in any state, including mid-DRAIN: full reset values on the next edge. No further pushes.

Decomposition:
- Package rram_readout_pkg:
  - state enum (IDLE, CAPTURE, DRAIN, DONE)
  - mode enum (RAW, ACC)
  - function therm2bin(popcount)
  - function therm_bubble
  - localparam helpers for WPF
- One sub-module, rram_therm2bin: a combinational per-channel converter instantiated NUM_ADC times by generate. It outputs the code and a bubble flag.

Test Plan:
1. Raw mode, all channels therm=15'h00FF, one adc_valid, full=0 -> two pushes of 64'h8888_8888_8888_8888, then a done pulse; therm_err stays 0.
2. Raw mode, channel i therm=(1<<(i%16))-1 -> words 0 and 1 both equal 64'hFEDC_BA98_7654_3210.
3. Accumulate mode, acc_cycles_m1=3, four samples of 15'h7FFF -> eight pushes of 64'h003C_003C_003C_003C; busy falls after done.
4. Case 3 with full_oFIFO=1 for 5 cycles after word 2 -> push_n stays high while full. Words 3..7 follow in order; exactly 8 pushes total.
5. Raw mode, channel 3 therm=15'h0005, others 0 -> word0[15:12]=4'h2, therm_err pulses once. A separate adc_valid during DRAIN produces one sample_drop pulse with data unchanged.
6. reset during DRAIN after word 1 -> push_n=1 and busy=0 next cycle. A new start plus a raw sample then produces a correct 2-word frame with idx starting at 0.

Source files
------------

// File: rtl/rram_readout_pkg.sv
// Shared types and helpers for the RRAM ADC readout packer.
// Covers thermometer-to-binary conversion, bubble detection and frame sizing.
package rram_readout_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef enum logic {
        RAW = 1'b0,
        ACC = 1'b1
    } mode_e;

    // Widest thermometer code the helpers accept; narrower codes are zero-extended.
    localparam int unsigned THERM_MAX = 64;

    function automatic int unsigned therm2bin(input logic [THERM_MAX-1:0] t);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < THERM_MAX; i++) begin
            if (t[i]) n++;
        end
        return n;
    endfunction

    function automatic logic therm_bubble(input logic [THERM_MAX-1:0] t);
        logic b;
        b = 1'b0;
        for (int unsigned i = 1; i < THERM_MAX; i++) begin
            if (t[i] && !t[i-1]) b = 1'b1;
        end
        return b;
    endfunction

    function automatic int unsigned words_per_frame(input int unsigned n_fields,
                                                    input int unsigned field_w,
                                                    input int unsigned word_w);
        return (n_fields * field_w + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/rram_therm2bin.sv
// Per-channel thermometer converter: popcount code plus a bubble flag.
module rram_therm2bin
    import rram_readout_pkg::*;
#(
    parameter int unsigned TW = 15,
    parameter int unsigned CW = 4
) (
    input  logic [TW-1:0] therm_i,
    output logic [CW-1:0] code_o,
    output logic          bubble_o
);

    logic [THERM_MAX-1:0] ext;

    always_comb begin
        ext      = THERM_MAX'(therm_i);
        code_o   = CW'(therm2bin(ext));
        bubble_o = therm_bubble(ext);
    end

endmodule

// File: rtl/rram_adc_readout_packer.sv
// Captures NUM_ADC thermometer codes (raw or accumulated), packs them into
// DATAOUT_WIDTH words and drains them into the output FIFO under backpressure.
module rram_adc_readout_packer
    import rram_readout_pkg::*;
#(
    parameter int unsigned NUM_ADC         = 32,
    parameter int unsigned ADC_WIDTH_THERM = 15,
    parameter int unsigned ADC_WIDTH       = 4,
    parameter int unsigned ACC_WIDTH       = 16,
    parameter int unsigned MAX_ACC_CYCLES  = 16,
    parameter int unsigned DATAOUT_WIDTH   = 64,
    localparam int unsigned CNT_W = (MAX_ACC_CYCLES > 1) ? $clog2(MAX_ACC_CYCLES) : 1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       acc_mode,
    input  logic [CNT_W-1:0]           acc_cycles_m1,
    input  logic                       adc_valid,
    input  logic [ADC_WIDTH_THERM-1:0] ADCOUT_THERM [NUM_ADC],
    output logic                       push_n_oFIFO,
    input  logic                       full_oFIFO,
    output logic [DATAOUT_WIDTH-1:0]   din_oFIFO,
    output logic                       busy,
    output logic                       done,
    output logic                       therm_err,
    output logic                       sample_drop
);

    localparam int unsigned WPF_RAW = words_per_frame(NUM_ADC, ADC_WIDTH, DATAOUT_WIDTH);
    localparam int unsigned WPF_ACC = words_per_frame(NUM_ADC, ACC_WIDTH, DATAOUT_WIDTH);
    localparam int unsigned WPF_MAX = (WPF_ACC > WPF_RAW) ? WPF_ACC : WPF_RAW;
    localparam int unsigned IDX_W   = (WPF_MAX > 1) ? $clog2(WPF_MAX) : 1;
    localparam int unsigned FLAT_W  = WPF_MAX * DATAOUT_WIDTH;

    state_e                 state_q;
    mode_e                  mode_q;
    logic [CNT_W-1:0]       cycles_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [ACC_WIDTH-1:0]   acc_q [NUM_ADC];
    logic                   busy_q;
    logic                   done_q;
    logic                   therm_err_q;
    logic                   sample_drop_q;

    logic [ADC_WIDTH-1:0]   code [NUM_ADC];
    logic [NUM_ADC-1:0]     bubble;
    logic [ACC_WIDTH-1:0]   acc_sum [NUM_ADC];
    logic [FLAT_W-1:0]      raw_flat;
    logic [FLAT_W-1:0]      acc_flat;
    logic [FLAT_W-1:0]      sel_flat;
    logic [DATAOUT_WIDTH-1:0] word;
    logic [IDX_W-1:0]       last_idx;

    for (genvar g = 0; g < NUM_ADC; g++) begin : g_conv
        rram_therm2bin #(
            .TW (ADC_WIDTH_THERM),
            .CW (ADC_WIDTH)
        ) u_conv (
            .therm_i  (ADCOUT_THERM[g]),
            .code_o   (code[g]),
            .bubble_o (bubble[g])
        );
    end

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ADC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {{(ACC_WIDTH + 1 - ADC_WIDTH){1'b0}}, b};
        return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
    endfunction

    // Both packings are built over the largest frame so idx never indexes past the vector.
    always_comb begin
        raw_flat = '0;
        acc_flat = '0;
        for (int unsigned c = 0; c < NUM_ADC; c++) begin
            acc_sum[c] = sat_add(acc_q[c], code[c]);
            raw_flat[c*ADC_WIDTH +: ADC_WIDTH] = acc_q[c][ADC_WIDTH-1:0];
            acc_flat[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[c];
        end
        sel_flat = (mode_q == ACC) ? acc_flat : raw_flat;
        word     = sel_flat[idx_q*DATAOUT_WIDTH +: DATAOUT_WIDTH];
        last_idx = (mode_q == ACC) ? IDX_W'(WPF_ACC - 1) : IDX_W'(WPF_RAW - 1);
    end

    always_comb begin
        push_n_oFIFO = (state_q == DRAIN) ? full_oFIFO : 1'b1;
        din_oFIFO    = (state_q == DRAIN) ? word : '0;
        busy         = busy_q;
        done         = done_q;
        therm_err    = therm_err_q;
        sample_drop  = sample_drop_q;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= IDLE;
            mode_q        <= RAW;
            cycles_q      <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            therm_err_q   <= 1'b0;
            sample_drop_q <= 1'b0;
            for (int unsigned c = 0; c < NUM_ADC; c++) acc_q[c] <= '0;
        end else begin
            done_q        <= 1'b0;
            therm_err_q   <= 1'b0;
            sample_drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (adc_valid) sample_drop_q <= 1'b1;
                    if (start) begin
                        mode_q   <= acc_mode ? ACC : RAW;
                        cycles_q <= acc_cycles_m1;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CAPTURE;
                        for (int unsigned c = 0; c < NUM_ADC; c++) acc_q[c] <= '0;
                    end
                end
                CAPTURE: begin
                    if (adc_valid) begin
                        for (int unsigned c = 0; c < NUM_ADC; c++) begin
                            acc_q[c] <= (mode_q == ACC) ? acc_sum[c] : ACC_WIDTH'(code[c]);
                        end
                        therm_err_q <= |bubble;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        if (mode_q == RAW || cnt_q == cycles_q) begin
                            idx_q   <= '0;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (adc_valid) sample_drop_q <= 1'b1;
                    if (!full_oFIFO) begin
                        if (idx_q == last_idx) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (adc_valid) sample_drop_q <= 1'b1;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rram_adc_readout_packer.sv
// Directed bench for rram_adc_readout_packer with default parameters.
module tb_rram_adc_readout_packer;

    localparam int unsigned N = 32;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        acc_mode;
    logic [3:0]  acc_cycles_m1;
    logic        adc_valid;
    logic [14:0] therm [N];
    logic        push_n;
    logic        full;
    logic [63:0] din;
    logic        busy;
    logic        done;
    logic        therm_err;
    logic        sample_drop;

    int checks = 0;
    int errors = 0;
    int terr_cnt = 0;
    int drop_cnt = 0;
    logic [63:0] pushed_q [$];

    rram_adc_readout_packer dut (
        .CLK           (CLK),
        .reset         (reset),
        .start         (start),
        .acc_mode      (acc_mode),
        .acc_cycles_m1 (acc_cycles_m1),
        .adc_valid     (adc_valid),
        .ADCOUT_THERM  (therm),
        .push_n_oFIFO  (push_n),
        .full_oFIFO    (full),
        .din_oFIFO     (din),
        .busy          (busy),
        .done          (done),
        .therm_err     (therm_err),
        .sample_drop   (sample_drop)
    );

    always #5 CLK = ~CLK;

    // Inputs only change just after posedge, so negedge sees what the next edge commits.
    always @(negedge CLK) begin
        if (push_n === 1'b0) pushed_q.push_back(din);
        if (therm_err === 1'b1) terr_cnt++;
        if (sample_drop === 1'b1) drop_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic mode, input logic [3:0] m1);
        start = 1'b1; acc_mode = mode; acc_cycles_m1 = m1;
        tick();
        start = 1'b0;
    endtask

    task automatic sample();
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic set_all(input logic [14:0] v);
        for (int i = 0; i < N; i++) therm[i] = v;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 200 && done !== 1'b1; k++) tick();
        check(tag, done, 1);
    endtask

    task automatic wait_pushes(input int n);
        for (int k = 0; k < 200 && pushed_q.size() < n; k++) tick();
    endtask

    int t0;
    int d0;
    int n0;

    initial begin
        reset = 1'b1; start = 1'b0; acc_mode = 1'b0; acc_cycles_m1 = '0;
        adc_valid = 1'b0; full = 1'b0;
        set_all('0);
        tick(); tick();
        reset = 1'b0;
        check("rst_push_n", push_n, 1);
        check("rst_din", din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_therm_err", therm_err, 0);
        check("rst_sample_drop", sample_drop, 0);

        // 1: raw, every channel code 8
        pushed_q.delete(); t0 = terr_cnt;
        set_all(15'h00FF);
        start_frame(1'b0, 4'd0);
        check("t1_busy_rise", busy, 1);
        sample();
        wait_done("t1_done");
        check("t1_npush", pushed_q.size(), 2);
        check("t1_w0", pushed_q[0], 64'h8888_8888_8888_8888);
        check("t1_w1", pushed_q[1], 64'h8888_8888_8888_8888);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_busy_fall", busy, 0);
        check("t1_therm_err", terr_cnt - t0, 0);

        // 2: raw, channel i code = i%16
        pushed_q.delete();
        for (int i = 0; i < N; i++) therm[i] = 15'((32'd1 << (i % 16)) - 1);
        start_frame(1'b0, 4'd0);
        sample();
        wait_done("t2_done");
        check("t2_npush", pushed_q.size(), 2);
        check("t2_w0", pushed_q[0], 64'hFEDC_BA98_7654_3210);
        check("t2_w1", pushed_q[1], 64'hFEDC_BA98_7654_3210);
        tick();

        // 3: accumulate 4 samples of code 15 -> 60 per channel
        pushed_q.delete();
        set_all(15'h7FFF);
        start_frame(1'b1, 4'd3);
        adc_valid = 1'b1;
        repeat (4) tick();
        adc_valid = 1'b0;
        wait_done("t3_done");
        check("t3_npush", pushed_q.size(), 8);
        for (int w = 0; w < 8; w++) check($sformatf("t3_w%0d", w), pushed_q[w], 64'h003C_003C_003C_003C);
        tick();
        check("t3_busy_fall", busy, 0);

        // 4: same frame with backpressure after word 2
        pushed_q.delete();
        start_frame(1'b1, 4'd3);
        adc_valid = 1'b1;
        repeat (4) tick();
        adc_valid = 1'b0;
        wait_pushes(3);
        check("t4_pre_hold", pushed_q.size(), 3);
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t4_hold_push_n%0d", k), push_n, 1);
            tick();
        end
        check("t4_hold_npush", pushed_q.size(), 3);
        check("t4_hold_busy", busy, 1);
        full = 1'b0;
        wait_done("t4_done");
        check("t4_npush", pushed_q.size(), 8);
        for (int w = 0; w < 8; w++) check($sformatf("t4_w%0d", w), pushed_q[w], 64'h003C_003C_003C_003C);
        tick();

        // 5: bubble on channel 3, plus a sample arriving while draining
        pushed_q.delete(); t0 = terr_cnt; d0 = drop_cnt;
        set_all('0);
        therm[3] = 15'h0005;
        full = 1'b1;
        start_frame(1'b0, 4'd0);
        sample();
        set_all(15'h7FFF);
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        tick();
        check("t5_din_held", din, 64'h0000_0000_0000_2000);
        full = 1'b0;
        wait_done("t5_done");
        check("t5_npush", pushed_q.size(), 2);
        check("t5_w0", pushed_q[0], 64'h0000_0000_0000_2000);
        check("t5_w1", pushed_q[1], 64'h0);
        check("t5_therm_err", terr_cnt - t0, 1);
        check("t5_sample_drop", drop_cnt - d0, 1);
        tick();

        // 6: reset mid-drain, then a fresh raw frame
        pushed_q.delete();
        set_all(15'h7FFF);
        start_frame(1'b1, 4'd0);
        sample();
        wait_pushes(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_push_n", push_n, 1);
        check("t6_busy", busy, 0);
        check("t6_din", din, 0);
        n0 = pushed_q.size();
        repeat (5) tick();
        check("t6_no_push", pushed_q.size(), n0);
        pushed_q.delete();
        for (int i = 0; i < N; i++) therm[i] = (i < 16) ? 15'((32'd1 << i) - 1) : 15'h0;
        start_frame(1'b0, 4'd0);
        sample();
        wait_done("t6_done");
        check("t6_npush", pushed_q.size(), 2);
        check("t6_w0", pushed_q[0], 64'hFEDC_BA98_7654_3210);
        check("t6_w1", pushed_q[1], 64'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
